// File: rtl/dp_ram_be.sv
// dp_ram_be: byte-enable simple dual-port RAM with post-reset clear; define DP_RAM_PARITY_EN for per-byte parity and rd_perr
module dp_ram_be #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
`ifdef DP_RAM_PARITY_EN
  output logic                rd_perr,
`endif
  output logic                init_busy
);
  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [0:0] state_q, state_d;
  logic [IW-1:0] clr_q, clr_d;
  logic v1_q, v1_d;
  logic [DATA_W-1:0] d1_q, d1_d;
  logic rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic run, wr_in, wr_hit, rd_in, rd_go, mem_we, src_v;
  logic [IW-1:0] mem_idx;
  logic [NB-1:0] mem_be;
  logic [DATA_W-1:0] mem_wd, rd_old, rd_new, src_d;
`ifdef DP_RAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rd_par;
  logic rd_pe, p1_q, p1_d, rd_perr_q, rd_perr_d, src_p;
`endif
  // walk the clear counter through every word, then hand over to normal operation
  always_comb begin
    run = state_q == ST_RUN;
    state_d = (!run && clr_q == IW'(DEPTH - 1)) ? ST_RUN : state_q;
    clr_d = run ? clr_q : clr_q + 1'b1;
  end
  // single write source: clear walker during INIT, user port (in-range only) during RUN
  always_comb begin
    wr_in = {1'b0, wr_addr} < DEPTH_L;
    wr_hit = run && wr_en && wr_in;
    mem_we = !reset && (wr_hit || !run);
    mem_idx = run ? wr_addr[IW-1:0] : clr_q;
    mem_be = run ? wr_be : '1;
    mem_wd = run ? wr_data : '0;
  end
  // byte-masked storage update; parity is generated from the bytes actually written
  always_ff @(posedge clk)
    if (mem_we)
      for (int k = 0; k < NB; k++)
        if (mem_be[k]) begin
          mem_q[mem_idx][8*k +: 8] <= mem_wd[8*k +: 8];
`ifdef DP_RAM_PARITY_EN
          par_q[mem_idx][k] <= ^mem_wd[8*k +: 8];
`endif
        end
  // fetch the addressed word; bypass mode overlays the bytes being written this cycle
  always_comb begin
    rd_in = {1'b0, rd_addr} < DEPTH_L;
    rd_go = run && rd_en;
    rd_old = rd_in ? mem_q[rd_addr[IW-1:0]] : '0;
    rd_new = rd_old;
    for (int k = 0; k < NB; k++)
      if (RDW_MODE == 1 && wr_hit && wr_addr == rd_addr && wr_be[k]) rd_new[8*k +: 8] = wr_data[8*k +: 8];
  end
`ifdef DP_RAM_PARITY_EN
  // recheck even parity per byte of the returned word; bypassed bytes carry fresh parity
  always_comb begin
    rd_par = rd_in ? par_q[rd_addr[IW-1:0]] : '0;
    for (int k = 0; k < NB; k++)
      if (RDW_MODE == 1 && wr_hit && wr_addr == rd_addr && wr_be[k]) rd_par[k] = ^wr_data[8*k +: 8];
    rd_pe = 1'b0;
    for (int k = 0; k < NB; k++)
      rd_pe = rd_pe | (^{rd_new[8*k +: 8], rd_par[k]});
    rd_pe = rd_pe && rd_in;
  end
`endif
  // route reads through the optional second stage; output data holds between pulses
  always_comb begin
    v1_d = rd_go;
    d1_d = rd_go ? rd_new : d1_q;
    src_v = (RD_LAT == 2) ? v1_q : rd_go;
    src_d = (RD_LAT == 2) ? d1_q : rd_new;
    rd_valid_d = src_v;
    rd_data_d = src_v ? src_d : rd_data_q;
`ifdef DP_RAM_PARITY_EN
    p1_d = rd_go && rd_pe;
    src_p = (RD_LAT == 2) ? p1_q : rd_pe;
    rd_perr_d = src_v && src_p;
`endif
  end
  // control and read-pipeline registers; reset overrides every other input
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= ST_INIT;
      clr_q <= '0;
      v1_q <= 1'b0;
      d1_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
`ifdef DP_RAM_PARITY_EN
      p1_q <= 1'b0;
      rd_perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      v1_q <= v1_d;
      d1_q <= d1_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
`ifdef DP_RAM_PARITY_EN
      p1_q <= p1_d;
      rd_perr_q <= rd_perr_d;
`endif
    end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign init_busy = !run;
`ifdef DP_RAM_PARITY_EN
  assign rd_perr = rd_perr_q;
`endif
endmodule
